// File: rtl/photonic_core_pkg.sv
// photonic_core_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM states (LOAD, RUN, ERR)
//   WORD_WIDTH     : datapath instruction word width
//   NOP_WORD       : word returned on masked or out-of-range fetches
package photonic_core_pkg;
  typedef enum logic [1:0] {LOAD, RUN, ERR} loader_state_t;
  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] NOP_WORD = 16'h0000;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: DEPTH x DATA_WIDTH register array, one sync write port, two async read ports.
//   clk             : write clock, rising edge
//   we/waddr/wdata  : write enable, address, data
//   raddr_1/raddr_2 : read addresses
//   rdata_1/rdata_2 : combinational read data
// Contents are deliberately not reset.
module instr_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_1,
  input  logic [ADDR_WIDTH-1:0] raddr_2,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [DATA_WIDTH-1:0] rdata_2
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with sequential program-load path and core hold.
//   clk, rst (async, active-low)
//   address_1/address_2           : fetch addresses (PC, PC+1)
//   read_address_1/read_address_2 : combinational fetch data, NOP while held or out of range
//   load_valid/load_data/load_last/load_ready : program-load stream handshake
//   reload_req : pulse in RUN to start a new load
//   core_hold  : keep core in reset until a full program is loaded
//   load_error : sticky overflow flag (cleared only by rst)
//   load_count : words accepted in the current load
module instr_mem_loader
  import photonic_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           address_1,
  input  logic [15:0]           address_2,
  output logic [WORD_WIDTH-1:0] read_address_1,
  output logic [WORD_WIDTH-1:0] read_address_2,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload_req,
  output logic                  core_hold,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   load_count
);
  loader_state_t state_q, state_d;
  logic hs;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] rdata_1, rdata_2;
  // Writes are strictly sequential from 0, so the write pointer is the low bits of the count.
  assign wr_ptr = load_count[ADDR_WIDTH-1:0];
  assign hs = load_valid & load_ready;
  instr_mem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk(clk), .we(hs), .waddr(wr_ptr), .wdata(load_data),
    .raddr_1(address_1[ADDR_WIDTH-1:0]), .raddr_2(address_2[ADDR_WIDTH-1:0]),
    .rdata_1(rdata_1), .rdata_2(rdata_2)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= LOAD;
      load_count <= '0;
    end else begin
      state_q    <= state_d;
      load_count <= hs ? load_count + 1'b1 : (state_q == RUN && reload_req) ? '0 : load_count;
    end
  // A non-last word landing in the final slot leaves no room for the program end: overflow.
  always_comb begin
    state_d = state_q;
    state_d = state_q == LOAD ? (hs ? (load_last ? RUN : (wr_ptr == '1 ? ERR : LOAD)) : LOAD)
            : state_q == RUN  ? (reload_req ? LOAD : RUN)
            : ERR;
  end
  always_comb begin
    core_hold      = state_q != RUN;
    load_ready     = state_q == LOAD;
    load_error     = state_q == ERR;
    read_address_1 = (core_hold || |address_1[15:ADDR_WIDTH]) ? NOP_WORD : rdata_1;
    read_address_2 = (core_hold || |address_2[15:ADDR_WIDTH]) ? NOP_WORD : rdata_2;
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scoreboard bench; a full-size and a 4-word instance share stimulus.
module tb_instr_mem_loader;
  logic clk = 0, rst = 0;
  logic [15:0] address_1 = 0, address_2 = 0, load_data = 0;
  logic load_valid = 0, load_last = 0, reload_req = 0;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic a_ready, a_hold, a_err, b_ready, b_hold, b_err;
  logic [8:0] a_cnt;
  logic [2:0] b_cnt;
  int tests = 0, fails = 0;
  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .address_1(address_1), .address_2(address_2),
    .read_address_1(a_rd1), .read_address_2(a_rd2), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(a_ready),
    .reload_req(reload_req), .core_hold(a_hold), .load_error(a_err), .load_count(a_cnt));
  instr_mem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .address_1(address_1), .address_2(address_2),
    .read_address_1(b_rd1), .read_address_2(b_rd2), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(b_ready),
    .reload_req(reload_req), .core_hold(b_hold), .load_error(b_err), .load_count(b_cnt));

  task automatic exp(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last, input logic rl);
    load_valid = 1; load_data = d; load_last = last; reload_req = rl;
    tick();
    load_valid = 0; load_last = 0; reload_req = 0;
  endtask

  task automatic pulse_reload();
    reload_req = 1;
    tick();
    reload_req = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #2;
    tick();
    rst = 1;
  endtask

  initial begin
    // reset state, reads masked
    address_1 = 16'h0005; address_2 = 16'h0000;
    exp("rst_hold", 1); exp("rst_ready", 1); exp("rst_err", 0); exp("rst_cnt", 0);
    exp("rst_rd1", 16'h0000); exp("rst_rd2", 16'h0000);
    #3;
    chk(a_hold); chk(a_ready); chk(a_err); chk(a_cnt); chk(a_rd1); chk(a_rd2);
    tick();
    rst = 1;
    // basic load with an idle gap
    send(16'h1111, 0, 0);
    send(16'h2222, 0, 0);
    tick(); tick();
    exp("gap_cnt", 2); exp("gap_hold", 1);
    chk(a_cnt); chk(a_hold);
    send(16'h3333, 0, 0);
    exp("pre_last_hold", 1);
    chk(a_hold);
    exp("run_hold", 0); exp("run_cnt", 4); exp("run_ready", 0);
    send(16'h4444, 1, 0);
    chk(a_hold); chk(a_cnt); chk(a_ready);
    address_1 = 16'd2; address_2 = 16'd3;
    exp("rd_a2", 16'h3333); exp("rd_a3", 16'h4444);
    #1;
    chk(a_rd1); chk(a_rd2);
    address_1 = 16'd0; address_2 = 16'h0100;
    exp("rd_a0", 16'h1111); exp("rd_oor", 16'h0000);
    #1;
    chk(a_rd1); chk(a_rd2);
    // writes ignored in RUN
    load_valid = 1; load_data = 16'hDEAD;
    #1;
    exp("run_ready_valid", 0);
    chk(a_ready);
    tick(); tick();
    load_valid = 0;
    address_2 = 16'd4;
    exp("run_mem0", 16'h1111); exp("run_mem4", 16'hxxxx); exp("run_cnt2", 4);
    #1;
    chk(a_rd1);
    sb.pop_front();
    chk(a_cnt);
    // reload
    pulse_reload();
    exp("rl_hold", 1); exp("rl_cnt", 0); exp("rl_ready", 1); exp("rl_masked", 16'h0000);
    chk(a_hold); chk(a_cnt); chk(a_ready); chk(a_rd1);
    send(16'hAAAA, 1, 0);
    address_2 = 16'd1;
    exp("rl2_hold", 0); exp("rl2_mem0", 16'hAAAA); exp("rl2_mem1", 16'h2222); exp("rl2_cnt", 1);
    #1;
    chk(a_hold); chk(a_rd1); chk(a_rd2); chk(a_cnt);
    // reset mid-load aborts asynchronously
    pulse_reload();
    send(16'h5555, 0, 0);
    send(16'h6666, 0, 0);
    exp("mid_cnt", 2);
    chk(a_cnt);
    #2;
    rst = 0;
    #1;
    exp("arst_cnt", 0); exp("arst_hold", 1); exp("arst_ready", 1);
    chk(a_cnt); chk(a_hold); chk(a_ready);
    tick();
    rst = 1;
    // overflow on 4-word instance
    send(16'hB000, 0, 0);
    send(16'hB001, 0, 0);
    send(16'hB002, 0, 0);
    exp("ovf_pre_ready", 1); exp("ovf_pre_cnt", 3); exp("ovf_pre_err", 0);
    chk(b_ready); chk(b_cnt); chk(b_err);
    send(16'hB003, 0, 0);
    exp("ovf_err", 1); exp("ovf_hold", 1); exp("ovf_ready", 0); exp("ovf_cnt", 4);
    chk(b_err); chk(b_hold); chk(b_ready); chk(b_cnt);
    pulse_reload();
    tick();
    exp("ovf_rl_err", 1); exp("ovf_rl_hold", 1); exp("ovf_rl_cnt", 4);
    chk(b_err); chk(b_hold); chk(b_cnt);
    do_reset();
    exp("ovf_clr_err", 0); exp("ovf_clr_ready", 1); exp("ovf_clr_cnt", 0);
    chk(b_err); chk(b_ready); chk(b_cnt);
    // boundary full load, with reload_req coinciding with a handshake in LOAD
    send(16'hC000, 0, 0);
    send(16'hC001, 0, 1);
    exp("bnd_rl_cnt", 2); exp("bnd_rl_ready", 1);
    chk(b_cnt); chk(b_ready);
    send(16'hC002, 0, 0);
    send(16'hC003, 1, 0);
    exp("bnd_hold", 0); exp("bnd_err", 0); exp("bnd_cnt", 4);
    chk(b_hold); chk(b_err); chk(b_cnt);
    address_1 = 16'h0004; address_2 = 16'h0003;
    exp("bnd_oor", 16'h0000); exp("bnd_mem3", 16'hC003);
    #1;
    chk(b_rd1); chk(b_rd2);
    address_1 = 16'h0001; address_2 = 16'h0000;
    exp("bnd_mem1", 16'hC001); exp("bnd_mem0", 16'hC000);
    #1;
    chk(b_rd1); chk(b_rd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
